aximm_burst_wr_ctrl: RTL and testbench
======================================

AXIMM_BURST_WR_CTRL -- requirements
Module: aximm_burst_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: AXI-MM data width in bits, a power of two >= 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64: AXI-MM address width.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum beats per burst, range 1..256.
REQ-004 SHALL have port ap_clk, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port ap_start, input, 1: request to start one job.
REQ-007 SHALL have port ap_ready, output, 1: one-cycle pulse when the job is accepted.
REQ-008 SHALL have port ap_done, output, 1: one-cycle pulse when the job completes.
REQ-009 SHALL have port ap_idle, output, 1: high only in IDLE.
REQ-010 SHALL have port dst_addr, input, ADDR_WIDTH: destination byte address, beat-aligned.
REQ-011 SHALL have port size_bytes, input, 32: bytes per pass.
REQ-012 SHALL have port times, input, 32: pass count.
REQ-013 SHALL have port fifo_rd_en, output, 1: pops the first-word-fall-through source FIFO.
REQ-014 SHALL have port fifo_rd_data, input, DATA_WIDTH: FIFO head word.
REQ-015 SHALL have port fifo_empty, input, 1: FIFO empty flag.
REQ-016 SHALL have ports m_axi_AWVALID (output, 1) and m_axi_AWREADY (input, 1): AW handshake.
REQ-017 SHALL have port m_axi_AWADDR, output, ADDR_WIDTH: burst start address.
REQ-018 SHALL have port m_axi_AWLEN, output, 8: beats-1; AWSIZE = log2(DATA_WIDTH/8) and AWBURST = INCR are constant outputs.
REQ-019 SHALL have ports m_axi_WVALID (output, 1) and m_axi_WREADY (input, 1): W handshake.
REQ-020 SHALL have ports m_axi_WDATA (output, DATA_WIDTH) and m_axi_WLAST (output, 1): write beat and last-beat marker.
REQ-021 SHALL have ports m_axi_BVALID (input, 1), m_axi_BREADY (output, 1) and m_axi_BRESP (input, 2): write response.
REQ-022 SHALL have port err, output, 1: sticky flag, set on any BRESP != OKAY.

Function
REQ-023 SHALL implement the FSM IDLE -> CALC -> AW -> W -> B, then back to CALC, or to IDLE when the job is done.
REQ-024 SHALL, in IDLE with ap_start high: pulse ap_ready, latch dst_addr, beats = size_bytes >> log2(DATA_WIDTH/8) and times, clear err, and go to CALC.
REQ-025 SHALL, when the latched beats or times is 0: pulse ap_done in CALC without issuing any AXI transaction, and return to IDLE.
REQ-026 SHALL, in CALC, set len = min(remaining beats, MAX_BURST), subject to REQ-034; CALC lasts exactly 1 cycle.
REQ-027 SHALL, in AW, hold AWVALID with a stable AWADDR and AWLEN = len-1 until AWREADY; W starts only after the AW handshake.
REQ-028 SHALL, in W, drive WVALID = !fifo_empty, WDATA = fifo_rd_data and fifo_rd_en = WVALID && WREADY; WLAST is high on beat len; state moves to B after the WLAST handshake.
REQ-029 SHALL never pop the FIFO outside W and never assert WVALID while the FIFO is empty; a stall holds all W outputs stable.
REQ-030 SHALL, in B, hold BREADY high; on BVALID, advance address += len*(DATA_WIDTH/8) and remaining -= len.
REQ-031 SHALL, when remaining reaches 0 at the end of a pass: decrement times, reload address = dst_addr and remaining = beats; on times reaching 0, pulse ap_done and go to IDLE.
REQ-032 SHALL keep only one burst outstanding; ap_start is ignored outside IDLE; a back-to-back ap_start in the cycle after ap_done is accepted.

Reset
REQ-033 SHALL, while ap_rst_n is low (including mid-burst): go to IDLE with ap_idle=1, err=0, and ap_ready, ap_done, AWVALID, WVALID, WLAST, BREADY, fifo_rd_en all 0; AWADDR and AWLEN reset to 0; no partial burst resumes after reset.

Configuration
REQ-034 SHALL, with macro AXIMM_4K_SPLIT_EN defined, additionally clamp len so that no burst crosses a 4096-byte address boundary; without the macro, no boundary clamp is applied.

Structure
REQ-035 SHALL take the FSM state enum, AXI BURST/RESP encodings and the 4096 constant from shared package aximm_pkg.
REQ-036 SHALL use one sub-module, aximm_burst_len_calc, which is combinational: remaining, address -> len.

Verification
REQ-037 SHALL cover: size_bytes=40, times=1, dst_addr=0x1000, FIFO always full -> bursts AWLEN 15/15/7 at 0x1000/0x1010/0x1020, then ap_done.
REQ-038 SHALL cover: size_bytes=4, times=3 -> three AW at 0x1000, each AWLEN=3, and 12 pops total.
REQ-039 SHALL cover: size_bytes=0 or times=0 -> ap_ready, then ap_done 1 cycle later, and no AWVALID.
REQ-040 SHALL cover: AXIMM_4K_SPLIT_EN defined, dst_addr=0xFF8, size_bytes=16 -> AWLEN 7 at 0xFF8, then AWLEN 7 at 0x1000; without the macro -> a single AWLEN 15 burst.
REQ-041 SHALL cover: random fifo_empty and WREADY stalls -> WDATA sequence matches FIFO order and WLAST appears on beat 16 only.
REQ-042 SHALL cover: BRESP=SLVERR on burst 2 -> err=1 until the next ap_start; ap_rst_n low mid-W -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/aximm_pkg.sv
// Shared definitions for the AXI-MM burst writer: FSM states, AXI encodings
// and the 4 KiB boundary size.
package aximm_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_AW   = 3'd2,
        S_W    = 3'd3,
        S_B    = 3'd4
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int AXI_4K_BYTES = 4096;

endpackage

// File: rtl/aximm_burst_wr_ctrl_if.sv
// AXI-MM write channel bundle (AW, W, B) seen from the burst writer.
interface aximm_burst_wr_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 64
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;

    modport master (
        output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
        output WVALID, WDATA, WLAST, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
        input  WVALID, WDATA, WLAST, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/aximm_burst_len_calc.sv
// Combinational burst length: min(remaining, MAX_BURST), further limited to the
// 4 KiB boundary when AXIMM_4K_SPLIT_EN is defined.
module aximm_burst_len_calc
    import aximm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic [31:0]           remaining,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [8:0]            len
);
    localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);

    logic [8:0]  len_max;
    logic [12:0] room_bytes;
    logic [12:0] room_beats;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr[ADDR_WIDTH-1:12];
    assign len_max        = (remaining < 32'(MAX_BURST)) ? remaining[8:0] : 9'(MAX_BURST);
    // Beats left before the next 4 KiB page; never zero because addr is beat-aligned.
    assign room_bytes     = 13'(AXI_4K_BYTES) - {1'b0, addr[11:0]};
    assign room_beats     = room_bytes >> SIZE_LOG2;

`ifdef AXIMM_4K_SPLIT_EN
    assign len = ({4'b0, len_max} > room_beats) ? room_beats[8:0] : len_max;
`else
    logic unused_room;
    assign unused_room = ^room_beats;
    assign len         = len_max;
`endif

endmodule

// File: rtl/aximm_burst_wr_ctrl.sv
// AXI-MM burst writer: drains a FWFT FIFO into `times` passes of size_bytes at dst_addr.
// Optional macro AXIMM_4K_SPLIT_EN keeps bursts inside 4 KiB pages.
//
// state  | meaning
// IDLE   | waiting for ap_start
// CALC   | pick next burst length (or finish an empty job)
// AW     | address phase, AWVALID held until AWREADY
// W      | data beats from the FIFO, WLAST on the final beat
// B      | wait for write response, advance address / pass
module aximm_burst_wr_ctrl
    import aximm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic                  ap_idle,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [31:0]           size_bytes,
    input  logic [31:0]           times,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    aximm_burst_wr_ctrl_if.master m_axi,
    output logic                  err
);
    localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_addr, cur_addr;
    logic [31:0]           beats, remaining, times_left;
    logic [8:0]            len_r, calc_len, wbeats_left;
    logic [7:0]            awlen_r;
    logic                  job_empty, pass_end, job_end, beat_last, w_hs;

    aximm_burst_len_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_len_calc (
        .remaining (remaining),
        .addr      (cur_addr),
        .len       (calc_len)
    );

    assign job_empty = (beats == 32'd0) || (times_left == 32'd0);
    assign pass_end  = (remaining == {23'd0, len_r});
    assign job_end   = pass_end && (times_left == 32'd1);
    assign beat_last = (wbeats_left == 9'd1);
    assign w_hs      = m_axi.WVALID && m_axi.WREADY;

    assign m_axi.AWADDR  = cur_addr;
    assign m_axi.AWLEN   = awlen_r;
    assign m_axi.AWSIZE  = 3'(SIZE_LOG2);
    assign m_axi.AWBURST = AXI_BURST_INCR;
    assign m_axi.WDATA   = fifo_rd_data;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ap_start) state_nxt = S_CALC;
            S_CALC:  state_nxt = job_empty ? S_IDLE : S_AW;
            S_AW:    if (m_axi.AWREADY) state_nxt = S_W;
            S_W:     if (w_hs && beat_last) state_nxt = S_B;
            S_B:     if (m_axi.BVALID) state_nxt = job_end ? S_IDLE : S_CALC;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ap_ready      = 1'b0;
        ap_done       = 1'b0;
        ap_idle       = 1'b0;
        fifo_rd_en    = 1'b0;
        m_axi.AWVALID = 1'b0;
        m_axi.WVALID  = 1'b0;
        m_axi.WLAST   = 1'b0;
        m_axi.BREADY  = 1'b0;
        case (state)
            S_IDLE: begin
                ap_idle  = 1'b1;
                ap_ready = ap_start;
            end
            S_CALC:  ap_done = job_empty;
            S_AW:    m_axi.AWVALID = 1'b1;
            S_W: begin
                m_axi.WVALID = !fifo_empty;
                m_axi.WLAST  = beat_last;
                fifo_rd_en   = !fifo_empty && m_axi.WREADY;
            end
            S_B: begin
                m_axi.BREADY = 1'b1;
                ap_done      = m_axi.BVALID && job_end;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            base_addr   <= '0;
            cur_addr    <= '0;
            beats       <= '0;
            remaining   <= '0;
            times_left  <= '0;
            len_r       <= '0;
            awlen_r     <= '0;
            wbeats_left <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (ap_start) begin
                    base_addr  <= dst_addr;
                    cur_addr   <= dst_addr;
                    beats      <= size_bytes >> SIZE_LOG2;
                    remaining  <= size_bytes >> SIZE_LOG2;
                    times_left <= times;
                    err        <= 1'b0;
                end
                S_CALC: if (!job_empty) begin
                    len_r       <= calc_len;
                    awlen_r     <= 8'(calc_len - 9'd1);
                    wbeats_left <= calc_len;
                end
                S_W: if (w_hs) wbeats_left <= wbeats_left - 9'd1;
                S_B: if (m_axi.BVALID) begin
                    if (m_axi.BRESP != AXI_RESP_OKAY) err <= 1'b1;
                    // End of a pass rewinds to the job's start for the next pass.
                    if (pass_end) begin
                        times_left <= times_left - 32'd1;
                        cur_addr   <= base_addr;
                        remaining  <= beats;
                    end else begin
                        cur_addr  <= cur_addr + (ADDR_WIDTH'(len_r) << SIZE_LOG2);
                        remaining <= remaining - 32'(len_r);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aximm_burst_wr_ctrl.sv
// Scoreboard bench for aximm_burst_wr_ctrl: job model pushes expected AW/W beats,
// a negedge monitor pops and compares; honours AXIMM_4K_SPLIT_EN in the model.
module tb_aximm_burst_wr_ctrl;
    import aximm_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 64;
    localparam int MB    = 16;
    localparam int BYTES = DW / 8;

    typedef struct packed { logic [63:0] addr; logic [7:0] len; } aw_t;
    typedef struct packed { logic [7:0] data; logic last; } w_t;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n, ap_start;
    logic          ap_ready, ap_done, ap_idle, err;
    logic [AW-1:0] dst_addr;
    logic [31:0]   size_bytes, times;
    logic          fifo_rd_en, fifo_empty;
    logic [DW-1:0] fifo_rd_data;

    aximm_burst_wr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

    aximm_burst_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .dst_addr(dst_addr), .size_bytes(size_bytes), .times(times),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .m_axi(axi), .err(err)
    );

    always #5 ap_clk = ~ap_clk;

    int  checks = 0, errors = 0;
    aw_t exp_aw[$];
    w_t  exp_w[$];
    logic [7:0] src_q[$];
    int  pops_seen = 0, pops_applied = 0, wlast_cnt = 0, b_hs_cnt = 0, b_done = 0;
    int  aw_seen = 0, err_abs = 0;
    bit  stall = 0;
    bit  last_err = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: split each pass into bursts by plain arithmetic.
    function automatic void model_job(input logic [63:0] addr, input int size, input int tms,
                                      output int n_pops, output int n_aw);
        int beats, rem, len, room;
        logic [63:0] a;
        logic [7:0] d;
        beats  = size / BYTES;
        n_pops = 0;
        n_aw   = 0;
        if (beats > 0) begin
            for (int p = 0; p < tms; p++) begin
                a   = addr;
                rem = beats;
                while (rem > 0) begin
                    len  = (rem < MB) ? rem : MB;
                    room = (4096 - int'(a % 64'd4096)) / BYTES;
`ifdef AXIMM_4K_SPLIT_EN
                    if (len > room) len = room;
`endif
                    exp_aw.push_back('{a, 8'(len - 1)});
                    for (int i = 0; i < len; i++) begin
                        d = 8'($urandom);
                        src_q.push_back(d);
                        exp_w.push_back('{d, (i == len - 1)});
                    end
                    n_pops += len;
                    n_aw++;
                    a   += 64'(len * BYTES);
                    rem -= len;
                end
            end
        end
    endfunction

    // Slave + FIFO driver: applies events recorded by the monitor one step after the edge.
    initial begin
        bit popped;
        fifo_empty = 1'b1; fifo_rd_data = '0;
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = AXI_RESP_OKAY;
        forever begin
            @(posedge ap_clk); #1;
            popped = 0;
            while (pops_applied < pops_seen) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                pops_applied++;
                popped = 1;
            end
            if (b_hs_cnt > b_done) begin
                axi.BVALID = 1'b0;
                b_done++;
            end
            if (!axi.BVALID && b_done < wlast_cnt && (!stall || $urandom_range(0, 1) == 1)) begin
                axi.BVALID = 1'b1;
                axi.BRESP  = (b_done + 1 == err_abs) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
            if (src_q.size() == 0) fifo_empty = 1'b1;
            else if (fifo_empty || popped) fifo_empty = stall && ($urandom_range(0, 2) == 0);
            fifo_rd_data = (src_q.size() > 0) ? src_q[0] : '0;
            axi.AWREADY  = !stall || ($urandom_range(0, 1) == 1);
            axi.WREADY   = !stall || ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: compares every handshake against the scoreboard queues.
    initial begin
        aw_t e;
        w_t  ew;
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n) begin
                if (axi.AWVALID && axi.AWREADY) begin
                    aw_seen++;
                    if (exp_aw.size() == 0) chk("aw_unexpected", axi.AWADDR, 64'hDEAD);
                    else begin
                        e = exp_aw.pop_front();
                        chk("awaddr", axi.AWADDR, e.addr);
                        chk("awlen", 64'(axi.AWLEN), 64'(e.len));
                    end
                end
                if (fifo_empty) begin
                    chk("wvalid_when_empty", 64'(axi.WVALID), 64'd0);
                    chk("rd_en_when_empty", 64'(fifo_rd_en), 64'd0);
                end
                if (fifo_rd_en) pops_seen++;
                if (axi.WVALID && axi.WREADY) begin
                    if (exp_w.size() == 0) chk("w_unexpected", 64'(axi.WDATA), 64'h1DEAD);
                    else begin
                        ew = exp_w.pop_front();
                        chk("wdata", 64'(axi.WDATA), 64'(ew.data));
                        chk("wlast", 64'(axi.WLAST), 64'(ew.last));
                    end
                    if (axi.WLAST) wlast_cnt++;
                end
                if (axi.BVALID && axi.BREADY) b_hs_cnt++;
            end
        end
    end

    task automatic run_job(input logic [63:0] addr, input int size, input int tms,
                           input bit stl, input int err_rel);
        int n_pops, n_aw, pops0, aw0, cyc, awv;
        bit done;
        stall   = stl;
        err_abs = (err_rel > 0) ? b_hs_cnt + err_rel : 0;
        model_job(addr, size, tms, n_pops, n_aw);
        pops0 = pops_seen;
        aw0   = aw_seen;
        @(posedge ap_clk); #2;
        ap_start = 1'b1; dst_addr = addr; size_bytes = 32'(size); times = 32'(tms);
        @(negedge ap_clk);
        chk("ap_ready", 64'(ap_ready), 64'd1);
        chk("ap_idle_at_start", 64'(ap_idle), 64'd1);
        chk("err_before_start", 64'(err), 64'(last_err));
        @(posedge ap_clk); #2;
        ap_start = 1'b0; dst_addr = {$urandom, $urandom}; size_bytes = $urandom; times = $urandom;
        done = 0; cyc = 0; awv = 0;
        while (!done && cyc < 5000) begin
            @(negedge ap_clk);
            cyc++;
            if (axi.AWVALID) awv++;
            if (cyc == 4) begin
                chk("start_ignored_busy", 64'(ap_ready), 64'd0);
                ap_start = 1'b0;
            end
            if (ap_done) done = 1;
            else if (cyc == 3) ap_start = 1'b1;
        end
        ap_start = 1'b0;
        if (!done) chk("ap_done_timeout", 64'(cyc), 64'd0);
        else begin
            if (size / BYTES == 0 || tms == 0) begin
                chk("zero_job_done_latency", 64'(cyc), 64'd1);
                chk("zero_job_no_awvalid", 64'(awv), 64'd0);
            end
            chk("aw_count", 64'(aw_seen - aw0), 64'(n_aw));
            chk("pop_count", 64'(pops_seen - pops0), 64'(n_pops));
            chk("aw_leftover", 64'(exp_aw.size()), 64'd0);
            chk("w_leftover", 64'(exp_w.size()), 64'd0);
        end
        last_err = (err_rel > 0) && (err_rel <= n_aw);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ap_idle"}, 64'(ap_idle), 64'd1);
        chk({tag, "_ap_ready"}, 64'(ap_ready), 64'd0);
        chk({tag, "_ap_done"}, 64'(ap_done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_awvalid"}, 64'(axi.AWVALID), 64'd0);
        chk({tag, "_wvalid"}, 64'(axi.WVALID), 64'd0);
        chk({tag, "_wlast"}, 64'(axi.WLAST), 64'd0);
        chk({tag, "_bready"}, 64'(axi.BREADY), 64'd0);
        chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        chk({tag, "_awaddr"}, axi.AWADDR, 64'd0);
        chk({tag, "_awlen"}, 64'(axi.AWLEN), 64'd0);
    endtask

    initial begin
        int n_pops, n_aw, pops0, cyc;
        logic [63:0] ra;
        ap_rst_n = 1'b0; ap_start = 1'b0; dst_addr = '0; size_bytes = '0; times = '0;
        repeat (3) @(negedge ap_clk);
        check_reset_outputs("rst");
        chk("awsize", 64'(axi.AWSIZE), 64'($clog2(BYTES)));
        chk("awburst", 64'(axi.AWBURST), 64'(AXI_BURST_INCR));
        @(posedge ap_clk); #2;
        ap_rst_n = 1'b1;

        run_job(64'h1000, 40, 1, 0, 0);
        run_job(64'h1000, 4, 3, 0, 0);
        run_job(64'h1000, 0, 5, 0, 0);
        run_job(64'h1000, 8, 0, 0, 0);
        run_job(64'hFF8, 16, 1, 0, 0);
        run_job(64'h2000, 16, 2, 1, 0);
        for (int k = 0; k < 5; k++) begin
            ra = {48'd0, 4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095))};
            run_job(ra, $urandom_range(1, 60), $urandom_range(1, 3), 1, 0);
        end
        run_job(64'h3000, 40, 1, 0, 2);
        run_job(64'h1000, 4, 1, 0, 0);
        run_job(64'h3000, 48, 1, 1, 2);

        // Reset in the middle of a W burst, then a fresh job must not see leftovers.
        stall = 1; err_abs = 0;
        model_job(64'h4000, 32, 1, n_pops, n_aw);
        pops0 = pops_seen;
        @(posedge ap_clk); #2;
        ap_start = 1'b1; dst_addr = 64'h4000; size_bytes = 32; times = 1;
        @(posedge ap_clk); #2;
        ap_start = 1'b0;
        cyc = 0;
        while (pops_seen < pops0 + 4 && cyc < 2000) begin
            @(negedge ap_clk);
            cyc++;
        end
        chk("reached_mid_w", 64'(pops_seen >= pops0 + 4), 64'd1);
        @(posedge ap_clk); #2;
        ap_rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_w");
        exp_aw.delete(); exp_w.delete(); src_q.delete();
        pops_applied = pops_seen; b_hs_cnt = wlast_cnt; b_done = wlast_cnt;
        axi.BVALID = 1'b0; stall = 0; last_err = 0;
        @(negedge ap_clk);
        check_reset_outputs("rst_hold");
        @(posedge ap_clk); #2;
        ap_rst_n = 1'b1;
        run_job(64'h5000, 20, 1, 0, 0);
        run_job(64'h6000, 24, 2, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
